bs_dat_pipe: RTL and testbench

Parametrised, pipelined successor to the block-scaling datapath stage. Takes a wide signed accumulator word with a per-beat scale configuration, arithmetic-shifts it right, rounds half-up, and saturates to a narrow signed output. Sideband flags travel with each beat. It sits between wide accumulators (FFT/filter) and narrow sample buses, with req/ack flow control on both sides and a saturation event counter for gain control firmware.

---
 rtl/bs_dat_pkg.sv | 22 ++
 rtl/bs_dat_sat.sv | 32 +++
 rtl/bs_dat_pipe.sv | 124 ++++++++++++
 tb/tb_bs_dat_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bs_dat_pkg.sv
// Shared constants for the block-scaling datapath: config field layout and
// output flag positions.
package bs_dat_pkg;

    localparam int CFG_SHIFT_LSB = 0;
    localparam int CFG_SHIFT_W   = 6;
    localparam int CFG_RND       = 6;
    localparam int CFG_SAT       = 7;

    localparam int FLG_NEG  = 0;
    localparam int FLG_RND  = 1;
    localparam int FLG_SAT  = 2;
    localparam int FLG_CERR = 3;

    // Per-beat config byte as carried on t_cfg_dat
    typedef struct packed {
        logic                   sat_en;
        logic                   round_en;
        logic [CFG_SHIFT_W-1:0] shift;
    } cfg_t;

endpackage

// File: rtl/bs_dat_sat.sv
// Round-add, overflow detect and clamp/wrap from a wide shifted word down to
// the narrow output width. Purely combinational.
module bs_dat_sat #(
    parameter int T_0_DAT_WIDTH = 36,
    parameter int I_0_DAT_WIDTH = 16
) (
    input  logic [T_0_DAT_WIDTH-1:0] shifted,
    input  logic                     rnd,
    input  logic                     sat_en,
    output logic [I_0_DAT_WIDTH-1:0] dat,
    output logic                     ovf
);

    localparam int UW = T_0_DAT_WIDTH - I_0_DAT_WIDTH + 2;

    logic [T_0_DAT_WIDTH:0] sum;
    logic [UW-1:0]          upper;

    // One extra bit of headroom so the +1 round can never wrap
    assign sum   = {shifted[T_0_DAT_WIDTH-1], shifted} + {{T_0_DAT_WIDTH{1'b0}}, rnd};
    // Fits in I bits exactly when everything from the output sign bit up is a sign extension
    assign upper = sum[T_0_DAT_WIDTH:I_0_DAT_WIDTH-1];
    assign ovf   = !((&upper) | ~(|upper));

    always_comb begin
        dat = sum[I_0_DAT_WIDTH-1:0];
        if (ovf && sat_en)
            dat = sum[T_0_DAT_WIDTH] ? {1'b1, {(I_0_DAT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(I_0_DAT_WIDTH-1){1'b1}}};
    end

endmodule

// File: rtl/bs_dat_pipe.sv
// Two-stage block-scaling pipe: stage A shifts and captures the round bit,
// stage B rounds/saturates into the output register. req/ack on both sides.
module bs_dat_pipe
    import bs_dat_pkg::*;
#(
    parameter int T_0_DAT_WIDTH = 36,
    parameter int I_0_DAT_WIDTH = 16,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [T_0_DAT_WIDTH-1:0] t_0_dat,
    input  logic [7:0]               t_cfg_dat,
    input  logic                     t_0_req,
    output logic                     t_0_ack,
    output logic [I_0_DAT_WIDTH-1:0] i_0_dat,
    output logic [3:0]               i_0_flg,
    output logic                     i_0_req,
    input  logic                     i_0_ack,
    output logic [SAT_CNT_WIDTH-1:0] sat_cnt,
    input  logic                     sat_cnt_clr
);

    localparam int STAGES = 2;
    localparam logic [CFG_SHIFT_W-1:0] MAX_SHIFT = CFG_SHIFT_W'(T_0_DAT_WIDTH - 1);

    // vld_pipe[1] = stage A, vld_pipe[2] = stage B (output register)
    logic [STAGES:1] vld_pipe;
    logic            a_ack;
    logic            b_ack;

    cfg_t                   cfg;
    logic                   cerr_in;
    logic [CFG_SHIFT_W-1:0] eff_shift;
    logic [T_0_DAT_WIDTH-1:0] shifted_in;
    logic [T_0_DAT_WIDTH-1:0] rbit_src;
    logic                     rbit_in;

    logic [T_0_DAT_WIDTH-1:0] a_shifted;
    logic                     a_rbit;
    logic                     a_neg;
    logic                     a_rnd_en;
    logic                     a_sat_en;
    logic                     a_cerr;

    logic [I_0_DAT_WIDTH-1:0] b_dat;
    logic                     b_ovf;
    logic                     b_rnd;
    logic [3:0]               flg_nxt;

    assign b_ack   = !vld_pipe[2] | i_0_ack;
    assign a_ack   = !vld_pipe[1] | b_ack;
    assign t_0_ack = a_ack;
    assign i_0_req = vld_pipe[2];

    assign cfg        = cfg_t'(t_cfg_dat);
    assign cerr_in    = int'(cfg.shift) >= T_0_DAT_WIDTH;
    assign eff_shift  = cerr_in ? MAX_SHIFT : cfg.shift;
    assign shifted_in = $signed(t_0_dat) >>> eff_shift;
    // Last bit shifted out; the shift amount is floored at 0 so no out-of-range select
    assign rbit_src   = t_0_dat >> ((eff_shift == '0) ? '0 : eff_shift - 1'b1);
    assign rbit_in    = (eff_shift != '0) & rbit_src[0];

    assign b_rnd = a_rnd_en & a_rbit;

    bs_dat_sat #(
        .T_0_DAT_WIDTH (T_0_DAT_WIDTH),
        .I_0_DAT_WIDTH (I_0_DAT_WIDTH)
    ) u_sat (
        .shifted (a_shifted),
        .rnd     (b_rnd),
        .sat_en  (a_sat_en),
        .dat     (b_dat),
        .ovf     (b_ovf)
    );

    always_comb begin
        flg_nxt           = '0;
        flg_nxt[FLG_NEG]  = a_neg;
        flg_nxt[FLG_RND]  = b_rnd;
        flg_nxt[FLG_SAT]  = b_ovf;
        flg_nxt[FLG_CERR] = a_cerr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            a_shifted <= '0;
            a_rbit    <= 1'b0;
            a_neg     <= 1'b0;
            a_rnd_en  <= 1'b0;
            a_sat_en  <= 1'b0;
            a_cerr    <= 1'b0;
            i_0_dat   <= '0;
            i_0_flg   <= '0;
            sat_cnt   <= '0;
        end else begin
            if (a_ack) begin
                vld_pipe[1] <= t_0_req;
                if (t_0_req) begin
                    a_shifted <= shifted_in;
                    a_rbit    <= rbit_in;
                    a_neg     <= t_0_dat[T_0_DAT_WIDTH-1];
                    a_rnd_en  <= cfg.round_en;
                    a_sat_en  <= cfg.sat_en;
                    a_cerr    <= cerr_in;
                end
            end
            if (b_ack) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    i_0_dat <= b_dat;
                    i_0_flg <= flg_nxt;
                end
            end
            // Clear beats a coincident increment; count sticks at all-ones
            if (sat_cnt_clr)
                sat_cnt <= '0;
            else if (i_0_req && i_0_ack && i_0_flg[FLG_SAT] && !(&sat_cnt))
                sat_cnt <= sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bs_dat_pipe.sv
// Self-checking bench for bs_dat_pipe: vector table plus random beats through
// a scoreboard, with hand sequences for backpressure, counter clear and flush.
module tb_bs_dat_pipe;

    localparam int T = 36;
    localparam int I = 16;
    localparam int S = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [T-1:0] t_0_dat;
    logic [7:0]   t_cfg_dat;
    logic         t_0_req;
    logic         t_0_ack;
    logic [I-1:0] i_0_dat;
    logic [3:0]   i_0_flg;
    logic         i_0_req;
    logic         i_0_ack;
    logic [S-1:0] sat_cnt;
    logic         sat_cnt_clr;

    bs_dat_pipe #(.T_0_DAT_WIDTH(T), .I_0_DAT_WIDTH(I), .SAT_CNT_WIDTH(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .t_0_dat     (t_0_dat),
        .t_cfg_dat   (t_cfg_dat),
        .t_0_req     (t_0_req),
        .t_0_ack     (t_0_ack),
        .i_0_dat     (i_0_dat),
        .i_0_flg     (i_0_flg),
        .i_0_req     (i_0_req),
        .i_0_ack     (i_0_ack),
        .sat_cnt     (sat_cnt),
        .sat_cnt_clr (sat_cnt_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [I-1:0] dat;
        logic [3:0]   flg;
    } exp_t;

    typedef struct {
        logic [T-1:0] dat;
        logic [7:0]   cfg;
        logic [I-1:0] edat;
        logic [3:0]   eflg;
    } vec_t;

    int     errors = 0;
    int     checks = 0;
    exp_t   sb[$];
    exp_t   cur_exp;
    logic [S-1:0] exp_cnt;
    bit     ack_rand = 0;
    bit     hold_v = 0;
    logic [I-1:0] hold_dat;
    logic [3:0]   hold_flg;
    vec_t   tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic on a sign-extended 64-bit copy
    function automatic exp_t model(input logic [T-1:0] d, input logic [7:0] c);
        exp_t   r;
        longint v, sh, sum;
        int     s, eff;
        bit     rb, re, se, cerr, ovf;
        v    = longint'($signed(d));
        s    = int'(c[5:0]);
        re   = c[6];
        se   = c[7];
        cerr = (s >= T);
        eff  = cerr ? T - 1 : s;
        sh   = v >>> eff;
        rb   = (eff == 0) ? 1'b0 : v[eff-1];
        sum  = sh + longint'(re & rb);
        ovf  = (sum > 32767) || (sum < -32768);
        if (ovf && se) r.dat = (sum < 0) ? 16'h8000 : 16'h7FFF;
        else           r.dat = sum[15:0];
        r.flg = {cerr, ovf, re & rb, d[T-1]};
        return r;
    endfunction

    task automatic send(input logic [T-1:0] d, input logic [7:0] c, input exp_t e);
        int n = 0;
        t_0_dat   = d;
        t_cfg_dat = c;
        cur_exp   = e;
        t_0_req   = 1'b1;
        @(negedge clk);
        while (!t_0_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!t_0_ack) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: t_0_ack stuck at %0b, required 1", t_0_ack);
        end
        @(posedge clk);
        #1;
        t_0_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding, required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (ack_rand) begin
            #1;
            i_0_ack = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: scoreboard push/pop, hold stability and sat_cnt model
    always @(negedge clk) begin
        exp_t e;
        bit   sat_hit;
        sat_hit = 1'b0;
        if (reset) begin
            sb.delete();
            exp_cnt = '0;
            hold_v  = 1'b0;
        end else begin
            chk("sat_cnt", sat_cnt, exp_cnt);
            if (hold_v) begin
                chk("hold_req", i_0_req, 1);
                chk("hold_dat", i_0_dat, hold_dat);
                chk("hold_flg", i_0_flg, hold_flg);
            end
            hold_v   = i_0_req && !i_0_ack;
            hold_dat = i_0_dat;
            hold_flg = i_0_flg;
            if (t_0_req && t_0_ack) sb.push_back(cur_exp);
            if (i_0_req && i_0_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: dat %0h flg %0h, required no beat", i_0_dat, i_0_flg);
                end else begin
                    e = sb.pop_front();
                    chk("out_dat", i_0_dat, e.dat);
                    chk("out_flg", i_0_flg, e.flg);
                    sat_hit = e.flg[2];
                end
            end
            if (sat_cnt_clr) exp_cnt = '0;
            else if (sat_hit && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        end
    end

    initial begin
        exp_t         e;
        logic [63:0]  r;
        logic [7:0]   c;
        int           n;

        tbl[0] = '{36'h00001234C, 8'hC4, 16'h1235, 4'b0010};
        tbl[1] = '{36'h000100000, 8'h84, 16'h7FFF, 4'b0100};
        tbl[2] = '{36'h000100000, 8'h04, 16'h0000, 4'b0100};
        tbl[3] = '{36'hFFFFFFFFF, 8'h41, 16'h0000, 4'b0011};
        tbl[4] = '{36'h800000000, 8'h28, 16'hFFFF, 4'b1001};
        tbl[5] = '{36'h800000000, 8'h84, 16'h8000, 4'b0101};
        tbl[6] = '{36'hFFFFFFFF8, 8'h44, 16'h0000, 4'b0011};
        tbl[7] = '{36'h000007FFF, 8'hC0, 16'h7FFF, 4'b0000};

        // Reset state, with a beat offered throughout
        reset       = 1'b1;
        t_0_req     = 1'b1;
        t_0_dat     = 36'h123456789;
        t_cfg_dat   = 8'h04;
        i_0_ack     = 1'b1;
        sat_cnt_clr = 1'b0;
        cur_exp     = '{16'h0, 4'h0};
        repeat (2) @(negedge clk);
        chk("rst_t0_ack", t_0_ack, 1);
        chk("rst_i0_req", i_0_req, 0);
        chk("rst_i0_dat", i_0_dat, 0);
        chk("rst_i0_flg", i_0_flg, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        t_0_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_beat_dropped", i_0_req, 0);
        end
        @(posedge clk);
        #1;

        // Latency on an empty pipe
        e.dat = tbl[0].edat;
        e.flg = tbl[0].eflg;
        send(tbl[0].dat, tbl[0].cfg, e);
        @(negedge clk);
        chk("lat_cycle1_req", i_0_req, 0);
        @(negedge clk);
        chk("lat_cycle2_req", i_0_req, 1);
        drain();

        // Vector table, back to back
        for (int k = 0; k < 8; k++) begin
            e.dat = tbl[k].edat;
            e.flg = tbl[k].eflg;
            send(tbl[k].dat, tbl[k].cfg, e);
        end
        drain();

        // Random beats under random downstream stalls
        ack_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            r = {$urandom, $urandom};
            c = 8'($urandom_range(0, 255));
            send(r[T-1:0], c, model(r[T-1:0], c));
        end
        ack_rand = 1'b0;
        @(posedge clk);
        #2;
        i_0_ack = 1'b1;
        drain();

        // Backpressure: third beat must wait until the output drains
        i_0_ack = 1'b0;
        e.dat = tbl[0].edat; e.flg = tbl[0].eflg;
        send(tbl[0].dat, tbl[0].cfg, e);
        e.dat = tbl[5].edat; e.flg = tbl[5].eflg;
        send(tbl[5].dat, tbl[5].cfg, e);
        fork
            begin
                e.dat = tbl[3].edat; e.flg = tbl[3].eflg;
                send(tbl[3].dat, tbl[3].cfg, e);
            end
            begin
                @(negedge clk);
                chk("bp_t0_ack_low", t_0_ack, 0);
                repeat (4) @(posedge clk);
                #1;
                i_0_ack = 1'b1;
            end
        join
        drain();

        // Clear coincident with a saturated output transfer
        i_0_ack = 1'b0;
        e.dat = tbl[1].edat; e.flg = tbl[1].eflg;
        send(tbl[1].dat, tbl[1].cfg, e);
        n = 0;
        while (!i_0_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("clr_setup_req", i_0_req, 1);
        @(posedge clk);
        #1;
        sat_cnt_clr = 1'b1;
        i_0_ack     = 1'b1;
        @(posedge clk);
        #1;
        sat_cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_wins", sat_cnt, 0);
        drain();

        // Build up a nonzero count, then reset with two beats in flight
        send(tbl[1].dat, tbl[1].cfg, '{tbl[1].edat, tbl[1].eflg});
        drain();
        i_0_ack = 1'b0;
        send(tbl[5].dat, tbl[5].cfg, '{tbl[5].edat, tbl[5].eflg});
        send(tbl[0].dat, tbl[0].cfg, '{tbl[0].edat, tbl[0].eflg});
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("flush_i0_req", i_0_req, 0);
        chk("flush_sat_cnt", sat_cnt, 0);
        i_0_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_no_beat", i_0_req, 0);
        end
        @(posedge clk);
        #1;
        send(tbl[6].dat, tbl[6].cfg, '{tbl[6].edat, tbl[6].eflg});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
